// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, word fetch over req/ready, instruction register to decode
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect targets become a faulting NOP)
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode,
    output logic        instr_fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_VALID = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] pending_pc, pending_pc_nx;
    logic        pending_bad, pending_bad_nx;
    logic [31:0] instr_nx, instr_pc_nx;
    logic        instr_valid_nx, instr_fault_nx;

    // Redirect target as seen by the fetch logic, plus whether it must fault.
    logic [31:0] tgt;
    logic        tgt_bad;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign tgt     = redirect_pc;
    assign tgt_bad = |redirect_pc[1:0];
`else
    logic unused_low_bits;
    assign tgt             = {redirect_pc[31:2], 2'b00};
    assign tgt_bad         = 1'b0;
    assign unused_low_bits = ^redirect_pc[1:0];
`endif

    // Destination chosen this cycle when a redirect (live or pending) takes effect.
    logic        take;
    logic [31:0] dest;
    logic        dest_bad;

    // Next-state and datapath update; redirect handling overrides the normal flow.
    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        pending_pc_nx  = pending_pc;
        pending_bad_nx = pending_bad;
        instr_nx       = instr;
        instr_pc_nx    = instr_pc;
        instr_valid_nx = instr_valid;
        instr_fault_nx = instr_fault;
        take           = 1'b0;
        dest           = tgt;
        dest_bad       = tgt_bad;

        case (state)
            S_IDLE: begin
                state_nx = S_FETCH;
                take     = redirect_valid;
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    if (mem_ready) begin
                        take = 1'b1;
                    end else begin
                        // Request already on the bus must finish before the new target goes out.
                        pending_pc_nx  = tgt;
                        pending_bad_nx = tgt_bad;
                        state_nx       = S_DRAIN;
                    end
                end else if (mem_ready) begin
                    instr_nx       = mem_rdata;
                    instr_pc_nx    = pc;
                    pc_nx          = pc + 32'd4;
                    instr_valid_nx = 1'b1;
                    instr_fault_nx = 1'b0;
                    state_nx       = S_VALID;
                end
            end
            S_DRAIN: begin
                if (mem_ready) begin
                    take = 1'b1;
                    if (!redirect_valid) begin
                        dest     = pending_pc;
                        dest_bad = pending_bad;
                    end
                end else if (redirect_valid) begin
                    pending_pc_nx  = tgt;
                    pending_bad_nx = tgt_bad;
                end
            end
            S_VALID: begin
                if (redirect_valid) begin
                    take = 1'b1;
                end else if (!stall) begin
                    instr_valid_nx = 1'b0;
                    instr_fault_nx = 1'b0;
                    state_nx       = S_FETCH;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (take) begin
            if (dest_bad) begin
                // Present a faulting NOP instead of fetching; resume at the aligned address if accepted.
                state_nx       = S_VALID;
                instr_nx       = NOP_INSTR;
                instr_pc_nx    = dest;
                instr_valid_nx = 1'b1;
                instr_fault_nx = 1'b1;
                pc_nx          = {dest[31:2], 2'b00};
            end else begin
                state_nx       = S_FETCH;
                pc_nx          = dest;
                instr_valid_nx = 1'b0;
                instr_fault_nx = 1'b0;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            pending_pc  <= RESET_PC;
            pending_bad <= 1'b0;
            instr       <= NOP_INSTR;
            instr_pc    <= RESET_PC;
            instr_valid <= 1'b0;
            instr_fault <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            pending_pc  <= pending_pc_nx;
            pending_bad <= pending_bad_nx;
            instr       <= instr_nx;
            instr_pc    <= instr_pc_nx;
            instr_valid <= instr_valid_nx;
            instr_fault <= instr_fault_nx;
        end
    end

    // pc only moves once the outstanding request is answered, so it is also the held address in DRAIN.
    assign mem_req  = (state == S_FETCH) || (state == S_DRAIN);
    assign mem_addr = pc;
    assign opcode   = instr[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: directed vector table plus randomized model comparison
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic        instr_fault;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode),
        .instr_fault    (instr_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        ready;
        logic        stl;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs[NV];

    task automatic setv(input int i, input logic rdy, input logic st, input logic rv,
                        input logic [31:0] rpc, input logic [31:0] rd,
                        input logic er, input logic [31:0] ea, input logic ev,
                        input logic [31:0] ei, input logic [31:0] ep);
        vecs[i].ready = rdy;  vecs[i].stl = st;     vecs[i].rv = rv;
        vecs[i].rpc = rpc;    vecs[i].rdata = rd;
        vecs[i].e_req = er;   vecs[i].e_addr = ea;  vecs[i].e_valid = ev;
        vecs[i].e_instr = ei; vecs[i].e_pc = ep;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0; mem_rdata = 32'h0; redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    // Behavioural reference: request/response bookkeeping with a one-entry output slot.
    logic        m_startup, m_req_open, m_discard, m_held;
    logic [31:0] m_pc, m_pend, m_held_instr, m_held_pc;

    task automatic model_reset();
        m_startup = 1'b1; m_req_open = 1'b0; m_discard = 1'b0; m_held = 1'b0;
        m_pc = 32'h0; m_pend = 32'h0; m_held_instr = 32'h13; m_held_pc = 32'h0;
    endtask

    task automatic model_step(input logic rdy, input logic st, input logic rv,
                              input logic [31:0] rpc, input logic [31:0] rd);
        logic [31:0] t;
        t = rpc & ~32'h3;
        if (m_startup) begin
            m_startup = 1'b0;
            if (rv) m_pc = t;
            m_req_open = 1'b1;
        end else if (m_held) begin
            if (rv) begin
                m_held = 1'b0; m_pc = t; m_req_open = 1'b1;
            end else if (!st) begin
                m_held = 1'b0; m_req_open = 1'b1;
            end
        end else if (m_req_open) begin
            if (rdy) begin
                if (m_discard) begin
                    m_discard = 1'b0;
                    m_pc = rv ? t : m_pend;
                end else if (rv) begin
                    m_pc = t;
                end else begin
                    m_held = 1'b1; m_held_instr = rd; m_held_pc = m_pc;
                    m_pc = m_pc + 32'd4; m_req_open = 1'b0;
                end
            end else if (rv) begin
                m_discard = 1'b1; m_pend = t;
            end
        end
    endtask

    initial begin
        logic [31:0] ei;
        logic        r_rdy, r_st, r_rv;
        logic [31:0] r_rpc, r_rd;

        // Directed sequence: startup, stall hold, delayed ready, redirects, drain, wraparound.
        setv(0,  1,0,0,32'h0,        32'h0,         0,32'h0,        0,32'h0,         32'h0);
        setv(1,  1,0,0,32'h0,        32'h1234_5037, 1,32'h0,        0,32'h0,         32'h0);
        setv(2,  0,0,0,32'h0,        32'h0,         0,32'h0,        1,32'h1234_5037, 32'h0);
        setv(3,  1,0,0,32'h0,        32'h0050_0093, 1,32'h4,        0,32'h0,         32'h0);
        for (int i = 4; i <= 8; i++)
            setv(i, 1,1,0,32'h0,     32'hFFFF_FFFF, 0,32'h0,        1,32'h0050_0093, 32'h4);
        setv(9,  0,0,0,32'h0,        32'h0,         0,32'h0,        1,32'h0050_0093, 32'h4);
        for (int i = 10; i <= 12; i++)
            setv(i, 0,0,0,32'h0,     32'h0,         1,32'h8,        0,32'h0,         32'h0);
        setv(13, 1,0,0,32'h0,        32'h0040_006F, 1,32'h8,        0,32'h0,         32'h0);
        setv(14, 0,1,1,32'h100,      32'h0,         0,32'h0,        1,32'h0040_006F, 32'h8);
        setv(15, 1,0,0,32'h0,        32'h0000_0463, 1,32'h100,      0,32'h0,         32'h0);
        setv(16, 0,0,0,32'h0,        32'h0,         0,32'h0,        1,32'h0000_0463, 32'h100);
        setv(17, 0,0,1,32'h200,      32'h0,         1,32'h104,      0,32'h0,         32'h0);
        setv(18, 0,0,1,32'h300,      32'h0,         1,32'h104,      0,32'h0,         32'h0);
        setv(19, 1,0,0,32'h0,        32'hDEAD_BEEF, 1,32'h104,      0,32'h0,         32'h0);
        setv(20, 1,0,0,32'h0,        32'h0020_8033, 1,32'h300,      0,32'h0,         32'h0);
        setv(21, 0,0,1,32'h102,      32'h0,         0,32'h0,        1,32'h0020_8033, 32'h300);
        setv(22, 1,0,0,32'h0,        32'h0010_0113, 1,32'h100,      0,32'h0,         32'h0);
        setv(23, 0,0,0,32'h0,        32'h0,         0,32'h0,        1,32'h0010_0113, 32'h100);
        setv(24, 1,0,1,32'hFFFF_FFFC,32'h0BAD_0013, 1,32'h104,      0,32'h0,         32'h0);
        setv(25, 1,0,0,32'h0,        32'h0000_0017, 1,32'hFFFF_FFFC,0,32'h0,         32'h0);
        setv(26, 0,0,0,32'h0,        32'h0,         0,32'h0,        1,32'h0000_0017, 32'hFFFF_FFFC);
        setv(27, 0,0,0,32'h0,        32'h0,         1,32'h0,        0,32'h0,         32'h0);

        do_reset();
        chk("rst_req",    32'(mem_req),     32'h0);
        chk("rst_addr",   mem_addr,         32'h0);
        chk("rst_valid",  32'(instr_valid), 32'h0);
        chk("rst_instr",  instr,            32'h13);
        chk("rst_pc",     instr_pc,         32'h0);
        chk("rst_opcode", 32'(opcode),      32'h13);
        chk("rst_fault",  32'(instr_fault), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            chk($sformatf("v%0d_req", i),   32'(mem_req),     32'(vecs[i].e_req));
            if (vecs[i].e_req)
                chk($sformatf("v%0d_addr", i), mem_addr,      vecs[i].e_addr);
            chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                ei = vecs[i].e_instr;
                chk($sformatf("v%0d_instr", i),  instr,       ei);
                chk($sformatf("v%0d_ipc", i),    instr_pc,    vecs[i].e_pc);
                chk($sformatf("v%0d_opcode", i), 32'(opcode), {25'h0, ei[6:0]});
            end
            chk($sformatf("v%0d_fault", i), 32'(instr_fault), 32'h0);
            mem_ready      = vecs[i].ready;
            stall          = vecs[i].stl;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            mem_rdata      = vecs[i].rdata;
            @(posedge clk);
            @(negedge clk);
        end

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_req", 32'(mem_req), 32'(m_req_open));
            if (m_req_open) chk("rnd_addr", mem_addr, m_pc);
            chk("rnd_valid", 32'(instr_valid), 32'(m_held));
            if (m_held) begin
                chk("rnd_instr",  instr,       m_held_instr);
                chk("rnd_ipc",    instr_pc,    m_held_pc);
                chk("rnd_opcode", 32'(opcode), {25'h0, m_held_instr[6:0]});
            end
            chk("rnd_fault", 32'(instr_fault), 32'h0);
            r_rdy = ($urandom_range(0, 1) == 1);
            r_st  = ($urandom_range(0, 2) == 0);
            r_rv  = ($urandom_range(0, 7) == 0);
            r_rpc = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            r_rd  = $urandom;
            mem_ready = r_rdy; stall = r_st; redirect_valid = r_rv; redirect_pc = r_rpc; mem_rdata = r_rd;
            model_step(r_rdy, r_st, r_rv, r_rpc, r_rd);
            @(posedge clk);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode stage.
- Decode contains the opcode-driven immediate-select decoder and the immediate extender.
- Holds the PC, issues word fetches over a req/ready memory port, and latches the returned word into an instruction register.
- Presents the instruction, its PC and opcode to decode under a valid/stall handshake, and accepts PC redirects from branch/jump resolution.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- NOP_INSTR, 32'h0000_0013, instruction register reset/fault value (addi x0,x0,0; opcode I-type).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_req  output  1  fetch request to instruction memory.
- mem_addr  output  32  fetch word address.
- mem_ready  input  1  memory response valid this cycle; sampled only while mem_req=1.
- mem_rdata  input  32  fetched word, valid when mem_ready=1.
- redirect_valid  input  1  load new PC (taken branch/jump/JALR), one-cycle pulse.
- redirect_pc  input  32  redirect target.
- stall  input  1  decode cannot accept this cycle.
- instr_valid  output  1  instr/instr_pc/opcode valid for decode.
- instr  output  32  instruction register.
- instr_pc  output  32  PC of instr.
- opcode  output  7  instr[6:0], combinational from register, feeds immediate-select decoder.
- instr_fault  output  1  misaligned-target fault flag (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, pending_pc=RESET_PC, instr=NOP_INSTR, instr_pc=RESET_PC, instr_valid=0, instr_fault=0, mem_req=0, mem_addr=RESET_PC.
- States: IDLE, FETCH, DRAIN, VALID.
- mem_req=1 in FETCH and DRAIN only.
- mem_addr=pc in FETCH and IDLE; in DRAIN it holds the abandoned address.
- Address stability: mem_addr must not change while mem_req=1 and mem_ready=0.
- IDLE: unconditionally -> FETCH next cycle. First request is issued in the 2nd cycle after reset release. A redirect in IDLE loads pc.
- FETCH, mem_ready=1, no redirect: instr<=mem_rdata, instr_pc<=pc, pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC+4=0), instr_valid<=1 -> VALID.
- FETCH, mem_ready=0, no redirect: stay; mem_addr held.
- FETCH, redirect, mem_ready=1: response discarded, pc<=target -> FETCH.
- FETCH, redirect, mem_ready=0: pending_pc<=target -> DRAIN; old request held until answered.
- DRAIN, mem_ready=1: response discarded, pc<=pending_pc (or redirect_pc if redirect same cycle) -> FETCH.
- DRAIN, redirect while waiting: pending_pc updated; latest redirect wins.
- VALID, stall=1, no redirect: all outputs held stable.
- VALID, stall=0: transfer accepted at edge; instr_valid<=0 -> FETCH with pc already advanced.
- VALID, redirect (priority over stall and accept): instr_valid<=0, pc<=target -> FETCH; held instruction dropped.
- Throughput: 2 cycles/instruction minimum (single-cycle mem_ready, no stall). Fetch-to-valid latency is 1 cycle after mem_ready.
- Redirect always has highest priority. No instruction fetched before a redirect is ever presented after it.
- instr_fault=0 in all states unless the feature below is compiled in.

Optional Feature:
- Macro FETCH_MISALIGN_CHECK_EN.
- Defined: redirect_pc[1:0]!=0 issues no fetch. Next state is VALID with instr=NOP_INSTR, instr_pc=redirect_pc, instr_valid=1, instr_fault=1. Fault clears on accept or on a later redirect. Applies in DRAIN too: fault is presented after the drain response arrives.
- Undefined: redirect_pc[1:0] forced to 2'b00; instr_fault tied 0.

Test Plan:
- Reset release, mem_ready=1 always -> mem_req=0 in cycle 1, mem_addr=0 in cycle 2; instr_valid=1 with instr_pc=0, 4, 8 on alternating cycles; opcode=mem_rdata[6:0].
- mem_ready delayed 3 cycles -> mem_addr constant for 4 cycles; instr_valid rises 1 cycle after mem_ready.
- Return 32'h00500093 (opcode 0010011), stall=1 for 5 cycles -> instr, instr_pc, instr_valid stable; no mem_req until stall drops.
- Redirect to 32'h100 while VALID holding PC 0x8 -> instr_valid=0 next cycle; next mem_addr=0x100; the 0x8 instruction is never accepted.
- Redirect to 0x200 then 0x300 during an unanswered fetch of 0x10 -> mem_addr stays 0x10 until mem_ready; its data is discarded; next fetch at 0x300.
- FETCH_MISALIGN_CHECK_EN, redirect_pc=32'h102 -> no mem_req; instr_valid=1, instr_fault=1, instr=32'h13, instr_pc=0x102. Without macro -> fetch at 0x100, instr_fault=0.
